// File: rtl/prm_sched_pkg.sv
// Shared types and sizing helpers for the PRM edge-check scheduler.
package prm_sched_pkg;

    localparam int unsigned DEF_N_EDGES = 512;
    localparam int unsigned DEF_LANES   = 16;
    localparam int unsigned DEF_OBS_W   = 15;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DUMP
    } sched_state_t;

    function automatic int unsigned banks_of(input int unsigned n_edges,
                                             input int unsigned lanes);
        return n_edges / lanes;
    endfunction

    // A single-bank array still needs a one-bit bank index.
    function automatic int unsigned bw_of(input int unsigned banks);
        return (banks > 1) ? $clog2(banks) : 1;
    endfunction

endpackage

// File: rtl/prm_edge_check_sched_if.sv
// Obstacle intake, checker-array broadcast and bitmap stream of the scheduler.
interface prm_edge_check_sched_if #(
    parameter int unsigned LANES = 16,
    parameter int unsigned OBS_W = 15,
    parameter int unsigned BW    = 5
);
    logic             obs_valid;
    logic             obs_ready;
    logic [OBS_W-1:0] obs_code;
    logic             obs_last;

    logic [OBS_W-1:0] chk_code;
    logic [BW-1:0]    chk_bank;
    logic [LANES-1:0] chk_mask;

    logic             mask_valid;
    logic             mask_ready;
    logic [BW-1:0]    mask_bank;
    logic [LANES-1:0] mask_word;
    logic             mask_last;

    modport master (
        output obs_valid, obs_code, obs_last, chk_mask, mask_ready,
        input  obs_ready, chk_code, chk_bank, mask_valid, mask_bank, mask_word, mask_last
    );

    modport slave (
        input  obs_valid, obs_code, obs_last, chk_mask, mask_ready,
        output obs_ready, chk_code, chk_bank, mask_valid, mask_bank, mask_word, mask_last
    );

endinterface

// File: rtl/prm_blk_bitmap.sv
// Per-frame blocked-edge bitmap: OR-accumulate write, combinational read,
// clear-on-read of the addressed bank and a synchronous clear on reset.
module prm_blk_bitmap #(
    parameter int unsigned BANKS = 32,
    parameter int unsigned LANES = 16,
    parameter int unsigned BW    = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [BW-1:0]    wr_bank,
    input  logic [LANES-1:0] wr_data,
    input  logic [BW-1:0]    rd_bank,
    input  logic             clr_en,
    output logic [LANES-1:0] rd_data
);

    logic [LANES-1:0] mem [BANKS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem <= '{default: '0};
        end else begin
            if (wr_en) begin
                mem[wr_bank] <= mem[wr_bank] | wr_data;
            end
            if (clr_en) begin
                mem[rd_bank] <= '0;
            end
        end
    end

    assign rd_data = mem[rd_bank];

endmodule

// File: rtl/prm_edge_check_sched.sv
// Sweeps each obstacle code across all checker banks, ORs blocked-edge bits
// per frame, then streams the frame bitmap one bank word at a time.
module prm_edge_check_sched
    import prm_sched_pkg::*;
#(
    parameter int unsigned N_EDGES = DEF_N_EDGES,
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned OBS_W   = DEF_OBS_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    prm_edge_check_sched_if.slave bus,
    output logic                 busy
);

    localparam int unsigned BANKS = banks_of(N_EDGES, LANES);
    localparam int unsigned BW    = bw_of(BANKS);
    localparam logic [BW-1:0] LAST_BANK = BW'(BANKS - 1);

    sched_state_t     state, state_n;
    logic [BW-1:0]    cnt, cnt_n;
    logic [OBS_W-1:0] code_q, code_n;
    logic             last_q, last_n;
    logic             at_last;

    logic             bm_wr_en;
    logic             bm_clr_en;
    logic [LANES-1:0] bm_rd_data;

    assign at_last = (cnt == LAST_BANK);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            code_q <= '0;
            last_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            code_q <= code_n;
            last_q <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        code_n  = code_q;
        last_n  = last_q;

        bus.obs_ready  = 1'b0;
        bus.chk_code   = code_q;
        bus.chk_bank   = '0;
        bus.mask_valid = 1'b0;
        bus.mask_bank  = '0;
        bus.mask_word  = '0;
        bus.mask_last  = 1'b0;
        busy           = 1'b1;
        bm_wr_en       = 1'b0;
        bm_clr_en      = 1'b0;

        case (state)
            IDLE: begin
                bus.obs_ready = 1'b1;
                busy          = 1'b0;
                if (bus.obs_valid) begin
                    code_n  = bus.obs_code;
                    last_n  = bus.obs_last;
                    cnt_n   = '0;
                    state_n = SWEEP;
                end
            end

            SWEEP: begin
                // chk_mask is the combinational answer for chk_bank this cycle.
                bus.chk_bank = cnt;
                bm_wr_en     = 1'b1;
                if (at_last) begin
                    cnt_n   = '0;
                    state_n = last_q ? DUMP : IDLE;
                end else begin
                    cnt_n = cnt + BW'(1);
                end
            end

            DUMP: begin
                bus.mask_valid = 1'b1;
                bus.mask_bank  = cnt;
                bus.mask_word  = bm_rd_data;
                bus.mask_last  = at_last;
                // Clearing on handshake leaves the bitmap empty for the next frame.
                if (bus.mask_ready) begin
                    bm_clr_en = 1'b1;
                    if (at_last) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + BW'(1);
                    end
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    prm_blk_bitmap #(
        .BANKS (BANKS),
        .LANES (LANES),
        .BW    (BW)
    ) u_bitmap (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bm_wr_en),
        .wr_bank (cnt),
        .wr_data (bus.chk_mask),
        .rd_bank (cnt),
        .clr_en  (bm_clr_en),
        .rd_data (bm_rd_data)
    );

endmodule

// File: tb/tb_prm_edge_check_sched.sv
// Self-checking bench: rule-table checker model and per-frame expected bitmap.
module tb_prm_edge_check_sched;

    localparam int unsigned BANKS = 32;
    localparam int unsigned LANES = 16;
    localparam int unsigned OBS_W = 15;
    localparam int unsigned BW    = 5;
    localparam int unsigned MAXR  = 128;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;

    int checks = 0;
    int passes = 0;

    prm_edge_check_sched_if #(.LANES(LANES), .OBS_W(OBS_W), .BW(BW)) bus ();

    prm_edge_check_sched #(.N_EDGES(512), .LANES(16), .OBS_W(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Checker-array model: a code blocks the listed lanes of the listed bank.
    logic [OBS_W-1:0] r_code [MAXR];
    logic [BW-1:0]    r_bank [MAXR];
    logic [LANES-1:0] r_mask [MAXR];
    int               n_rules = 0;

    function automatic logic [LANES-1:0] model_mask(input logic [OBS_W-1:0] c,
                                                    input logic [BW-1:0] b);
        logic [LANES-1:0] m;
        m = '0;
        for (int i = 0; i < n_rules; i++)
            if (r_code[i] == c && r_bank[i] == b) m = m | r_mask[i];
        return m;
    endfunction

    task automatic add_rule(input logic [OBS_W-1:0] c, input logic [BW-1:0] b,
                            input logic [LANES-1:0] m);
        if (n_rules < int'(MAXR)) begin
            r_code[n_rules] = c;
            r_bank[n_rules] = b;
            r_mask[n_rules] = m;
            n_rules++;
        end
    endtask

    // chk_bank/chk_code settle right after the edge; answer by mid-cycle.
    always @(negedge clk) bus.chk_mask = model_mask(bus.chk_code, bus.chk_bank);

    logic [LANES-1:0] exp_w [BANKS];

    task automatic clear_exp;
        for (int b = 0; b < int'(BANKS); b++) exp_w[b] = '0;
    endtask

    task automatic add_exp(input logic [OBS_W-1:0] c);
        for (int b = 0; b < int'(BANKS); b++) exp_w[b] = exp_w[b] | model_mask(c, BW'(b));
    endtask

    logic [BW-1:0]    got_bank [BANKS];
    logic [LANES-1:0] got_word [BANKS];
    logic             got_last [BANKS];
    int n_got, dump_cycles, wait_cycles, stall_bad;
    bit timed_out;

    task automatic send_obs(input logic [OBS_W-1:0] c, input logic l, output bit ok);
        ok = 1'b0;
        bus.obs_valid = 1'b1;
        bus.obs_code  = c;
        bus.obs_last  = l;
        for (int k = 0; k < 200; k++) begin
            if (bus.obs_ready === 1'b1) begin
                @(posedge clk); #1;
                bus.obs_valid = 1'b0;
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        bus.obs_valid = 1'b0;
    endtask

    // Gathers one bitmap dump; returns in the cycle after the final handshake.
    task automatic collect_dump(input int stall_bank, input int stall_len, input bit rand_ready);
        int stalled = 0;
        bit pend = 1'b0;
        logic [BW-1:0] pb = '0;
        logic [LANES-1:0] pw = '0;
        logic pl = 1'b0;
        n_got = 0; dump_cycles = 0; wait_cycles = 0; stall_bad = 0; timed_out = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (bus.mask_valid === 1'b1) begin
                if (pend && (bus.mask_bank !== pb || bus.mask_word !== pw || bus.mask_last !== pl))
                    stall_bad++;
                dump_cycles++;
                if (int'(bus.mask_bank) == stall_bank && stalled < stall_len) begin
                    bus.mask_ready = 1'b0;
                    stalled++;
                end else if (rand_ready) begin
                    bus.mask_ready = ($urandom_range(3) != 0);
                end else begin
                    bus.mask_ready = 1'b1;
                end
                if (bus.mask_ready) begin
                    if (n_got < int'(BANKS)) begin
                        got_bank[n_got] = bus.mask_bank;
                        got_word[n_got] = bus.mask_word;
                        got_last[n_got] = bus.mask_last;
                    end
                    n_got++;
                    pend = 1'b0;
                end else begin
                    pend = 1'b1;
                    pb = bus.mask_bank; pw = bus.mask_word; pl = bus.mask_last;
                end
            end else begin
                if (pend) stall_bad++;
                pend = 1'b0;
                if (dump_cycles == 0) wait_cycles++;
                bus.mask_ready = 1'b0;
            end
            @(posedge clk); #1;
            if (n_got > 0 && n_got <= int'(BANKS) && got_last[n_got-1] === 1'b1) begin
                bus.mask_ready = 1'b0;
                return;
            end
            if (n_got >= int'(BANKS)) begin
                bus.mask_ready = 1'b0;
                return;
            end
        end
        bus.mask_ready = 1'b0;
        timed_out = 1'b1;
    endtask

    task automatic test_reset;
        checks++;
        if ({bus.obs_ready, busy, bus.mask_valid, bus.mask_last} !== 4'b1000)
            $display("FAIL reset_flags got=%b exp=1000",
                     {bus.obs_ready, busy, bus.mask_valid, bus.mask_last});
        else passes++;
        checks++;
        if ({bus.chk_code, bus.chk_bank, bus.mask_bank, bus.mask_word} !== '0)
            $display("FAIL reset_values chk_code=%h chk_bank=%0d mask_bank=%0d mask_word=%h exp=0",
                     bus.chk_code, bus.chk_bank, bus.mask_bank, bus.mask_word);
        else passes++;
    endtask

    task automatic test_single;
        bit ok;
        add_rule(15'h1234, 5'd5, 16'h0008);
        clear_exp; add_exp(15'h1234);
        send_obs(15'h1234, 1'b1, ok);
        checks++;
        if (!ok) $display("FAIL single_accept got=timeout exp=accepted"); else passes++;
        checks++;
        if ({bus.obs_ready, busy, bus.chk_code, bus.chk_bank} !== {1'b0, 1'b1, 15'h1234, 5'd0})
            $display("FAIL single_sweep_start ready=%b busy=%b code=%h bank=%0d exp=0 1 1234 0",
                     bus.obs_ready, busy, bus.chk_code, bus.chk_bank);
        else passes++;
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (timed_out || wait_cycles != 32)
            $display("FAIL single_latency got=%0d timeout=%0d exp=32", wait_cycles, timed_out);
        else passes++;
        checks++;
        if (n_got != 32 || dump_cycles != 32)
            $display("FAIL single_count words=%0d cycles=%0d exp=32 32", n_got, dump_cycles);
        else passes++;
        checks++;
        if (got_word[5] !== 16'h0008)
            $display("FAIL single_bank5 got=%h exp=0008", got_word[5]);
        else passes++;
        for (int i = 0; i < 32 && i < n_got; i++) begin
            checks++;
            if (got_bank[i] !== BW'(i) || got_word[i] !== exp_w[i] || got_last[i] !== (i == 31))
                $display("FAIL single_word[%0d] bank=%0d word=%h last=%b exp=%0d %h %b",
                         i, got_bank[i], got_word[i], got_last[i], i, exp_w[i], (i == 31));
            else passes++;
        end
        checks++;
        if ({bus.obs_ready, busy, bus.mask_valid} !== 3'b100)
            $display("FAIL single_return_idle got=%b exp=100", {bus.obs_ready, busy, bus.mask_valid});
        else passes++;
    endtask

    task automatic test_two;
        bit ok1, ok2;
        add_rule(15'h0A01, 5'd2, 16'h0001);
        add_rule(15'h0A02, 5'd2, 16'h8000);
        clear_exp; add_exp(15'h0A01); add_exp(15'h0A02);
        send_obs(15'h0A01, 1'b0, ok1);
        send_obs(15'h0A02, 1'b1, ok2);
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (!ok1 || !ok2 || timed_out || n_got != 32)
            $display("FAIL two_frame ok=%b%b timeout=%0d words=%0d exp=11 0 32", ok1, ok2, timed_out, n_got);
        else passes++;
        checks++;
        if (got_word[2] !== 16'h8001) $display("FAIL two_bank2 got=%h exp=8001", got_word[2]);
        else passes++;
        for (int i = 0; i < 32 && i < n_got; i++) begin
            checks++;
            if (got_bank[i] !== BW'(i) || got_word[i] !== exp_w[i])
                $display("FAIL two_word[%0d] bank=%0d word=%h exp=%0d %h", i, got_bank[i], got_word[i], i, exp_w[i]);
            else passes++;
        end
    endtask

    task automatic test_sweep_timing;
        add_rule(15'h0333, 5'd31, 16'h8000);
        add_rule(15'h0444, 5'd0, 16'h0002);
        clear_exp; add_exp(15'h0333); add_exp(15'h0444);
        checks++;
        if (bus.obs_ready !== 1'b1) $display("FAIL sweep_ready_pre got=%b exp=1", bus.obs_ready);
        else passes++;
        bus.obs_valid = 1'b1; bus.obs_code = 15'h0333; bus.obs_last = 1'b0;
        @(posedge clk); #1;
        bus.obs_code = 15'h0444; bus.obs_last = 1'b1;
        for (int k = 0; k < 32; k++) begin
            checks++;
            if (bus.chk_bank !== BW'(k) || bus.obs_ready !== 1'b0)
                $display("FAIL sweep_step[%0d] bank=%0d ready=%b exp=%0d 0", k, bus.chk_bank, bus.obs_ready, k);
            else passes++;
            @(posedge clk); #1;
        end
        checks++;
        if (bus.obs_ready !== 1'b1 || bus.chk_bank !== '0)
            $display("FAIL sweep_second_accept ready=%b bank=%0d exp=1 0", bus.obs_ready, bus.chk_bank);
        else passes++;
        @(posedge clk); #1;
        bus.obs_valid = 1'b0;
        checks++;
        if (bus.chk_code !== 15'h0444 || busy !== 1'b1)
            $display("FAIL sweep_second_code code=%h busy=%b exp=0444 1", bus.chk_code, busy);
        else passes++;
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (timed_out || n_got != 32 || got_word[0] !== 16'h0002 || got_word[31] !== 16'h8000)
            $display("FAIL sweep_dump words=%0d w0=%h w31=%h exp=32 0002 8000", n_got, got_word[0], got_word[31]);
        else passes++;
    endtask

    task automatic test_dump_stall;
        bit ok;
        logic [LANES-1:0] m10, m11;
        m10 = LANES'($urandom) | 16'h0010;
        m11 = LANES'($urandom) | 16'h0001;
        add_rule(15'h1555, 5'd10, m10);
        add_rule(15'h1555, 5'd11, m11);
        clear_exp; add_exp(15'h1555);
        send_obs(15'h1555, 1'b1, ok);
        collect_dump(10, 3, 1'b0);
        checks++;
        if (!ok || timed_out || dump_cycles != 35)
            $display("FAIL stall_cycles got=%0d ok=%b timeout=%0d exp=35", dump_cycles, ok, timed_out);
        else passes++;
        checks++;
        if (stall_bad != 0) $display("FAIL stall_stable got=%0d changes exp=0", stall_bad);
        else passes++;
        checks++;
        if (n_got != 32) $display("FAIL stall_words got=%0d exp=32", n_got);
        else passes++;
        for (int i = 0; i < 32 && i < n_got; i++) begin
            checks++;
            if (got_bank[i] !== BW'(i) || got_word[i] !== exp_w[i])
                $display("FAIL stall_word[%0d] bank=%0d word=%h exp=%0d %h", i, got_bank[i], got_word[i], i, exp_w[i]);
            else passes++;
        end
    endtask

    task automatic test_back_to_back;
        bit ok1, ok2;
        add_rule(15'h0111, 5'd0, 16'h0001);
        send_obs(15'h0111, 1'b1, ok1);
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (!ok1 || n_got != 32 || got_word[0] !== 16'h0001)
            $display("FAIL b2b_frame1 words=%0d w0=%h exp=32 0001", n_got, got_word[0]);
        else passes++;
        checks++;
        if (bus.obs_ready !== 1'b1) $display("FAIL b2b_ready got=%b exp=1", bus.obs_ready);
        else passes++;
        send_obs(15'h0222, 1'b1, ok2);
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (!ok2 || timed_out || n_got != 32)
            $display("FAIL b2b_frame2 ok=%b words=%0d exp=1 32", ok2, n_got);
        else passes++;
        for (int i = 0; i < 32 && i < n_got; i++) begin
            checks++;
            if (got_bank[i] !== BW'(i) || got_word[i] !== '0)
                $display("FAIL b2b_word[%0d] bank=%0d word=%h exp=%0d 0000", i, got_bank[i], got_word[i], i);
            else passes++;
        end
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2;
        add_rule(15'h0ABC, 5'd3, 16'hFFFF);
        add_rule(15'h0ABC, 5'd7, 16'h00F0);
        add_rule(15'h0DEF, 5'd20, 16'h0101);
        send_obs(15'h0ABC, 1'b0, ok1);
        repeat (7) begin @(posedge clk); #1; end
        checks++;
        if (!ok1 || bus.chk_bank !== 5'd7) $display("FAIL rmid_bank got=%0d exp=7", bus.chk_bank);
        else passes++;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({bus.obs_ready, busy, bus.mask_valid, bus.chk_bank, bus.chk_code} !== {3'b100, 5'd0, 15'h0})
            $display("FAIL rmid_idle ready=%b busy=%b valid=%b bank=%0d code=%h exp=1 0 0 0 0",
                     bus.obs_ready, busy, bus.mask_valid, bus.chk_bank, bus.chk_code);
        else passes++;
        clear_exp; add_exp(15'h0DEF);
        send_obs(15'h0DEF, 1'b1, ok2);
        collect_dump(-1, 0, 1'b0);
        checks++;
        if (!ok2 || timed_out || n_got != 32) $display("FAIL rmid_frame words=%0d exp=32", n_got);
        else passes++;
        for (int i = 0; i < 32 && i < n_got; i++) begin
            checks++;
            if (got_word[i] !== exp_w[i])
                $display("FAIL rmid_word[%0d] got=%h exp=%h", i, got_word[i], exp_w[i]);
            else passes++;
        end
    endtask

    task automatic test_random;
        for (int f = 0; f < 5; f++) begin
            int nobs;
            logic [OBS_W-1:0] codes [3];
            bit ok, all_ok;
            nobs = int'($urandom_range(1, 3));
            for (int o = 0; o < nobs; o++) begin
                codes[o] = OBS_W'($urandom_range(0, 32767));
                for (int r = 0; r < int'($urandom_range(0, 2)); r++)
                    add_rule(codes[o], BW'($urandom_range(0, 31)), LANES'($urandom & $urandom));
            end
            clear_exp;
            for (int o = 0; o < nobs; o++) add_exp(codes[o]);
            all_ok = 1'b1;
            for (int o = 0; o < nobs; o++) begin
                send_obs(codes[o], (o == nobs - 1), ok);
                all_ok = all_ok & ok;
            end
            collect_dump(-1, 0, 1'b1);
            checks++;
            if (!all_ok || timed_out || n_got != 32 || stall_bad != 0)
                $display("FAIL rand%0d_frame ok=%b timeout=%0d words=%0d unstable=%0d exp=1 0 32 0",
                         f, all_ok, timed_out, n_got, stall_bad);
            else passes++;
            for (int i = 0; i < 32 && i < n_got; i++) begin
                checks++;
                if (got_bank[i] !== BW'(i) || got_word[i] !== exp_w[i] || got_last[i] !== (i == 31))
                    $display("FAIL rand%0d_word[%0d] bank=%0d word=%h last=%b exp=%0d %h %b",
                             f, i, got_bank[i], got_word[i], got_last[i], i, exp_w[i], (i == 31));
                else passes++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.obs_valid = 1'b0; bus.obs_code = '0; bus.obs_last = 1'b0;
        bus.mask_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_single;
        test_two;
        test_sweep_timing;
        test_dump_stall;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
